// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master to one-slave AXI-lite read arbiter (AR/R only).
// Optional macro ARB_FIXED_PRIO_EN: master 0 always wins ties instead of round-robin.
module axi_rd_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_ar_valid,
    output logic              s0_ar_ready,
    input  logic [ADDR_W-1:0] s0_ar_addr,
    output logic              s0_r_valid,
    input  logic              s0_r_ready,
    output logic [DATA_W-1:0] s0_r_data,
    output logic [1:0]        s0_r_resp,
    input  logic              s1_ar_valid,
    output logic              s1_ar_ready,
    input  logic [ADDR_W-1:0] s1_ar_addr,
    output logic              s1_r_valid,
    input  logic              s1_r_ready,
    output logic [DATA_W-1:0] s1_r_data,
    output logic [1:0]        s1_r_resp,
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [ADDR_W-1:0] m_ar_addr,
    input  logic              m_r_valid,
    output logic              m_r_ready,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic              gnt;
    logic              req_any;
    logic              sel0;
    logic              sel1;
    logic              idle;

`ifdef ARB_FIXED_PRIO_EN
    // Grant selection: master 0 wins whenever it is requesting.
    always_comb begin
        req_any = s0_ar_valid | s1_ar_valid;
        gnt     = ~s0_ar_valid;
    end
`else
    logic last;

    // Grant selection: a tie goes to the master that was not served last.
    always_comb begin
        req_any = s0_ar_valid | s1_ar_valid;
        if (s0_ar_valid && s1_ar_valid) begin
            gnt = ~last;
        end else begin
            gnt = ~s0_ar_valid;
        end
    end
`endif

    // AR accept and R routing; only the owner sees the slave's R channel.
    always_comb begin
        idle        = (state == IDLE);
        sel0        = (state == DATA) && !owner;
        sel1        = (state == DATA) && owner;
        s0_ar_ready = idle && s0_ar_valid && !gnt;
        s1_ar_ready = idle && s1_ar_valid && gnt;
        m_ar_addr   = addr_q;
        s0_r_valid  = sel0 && m_r_valid;
        s0_r_data   = sel0 ? m_r_data : '0;
        s0_r_resp   = sel0 ? m_r_resp : 2'b00;
        s1_r_valid  = sel1 && m_r_valid;
        s1_r_data   = sel1 ? m_r_data : '0;
        s1_r_resp   = sel1 ? m_r_resp : 2'b00;
        m_r_ready   = (sel0 && s0_r_ready) || (sel1 && s1_r_ready);
    end

    // Transaction FSM: capture address on grant, present it, await one R beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            addr_q     <= '0;
            m_ar_valid <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        addr_q     <= gnt ? s1_ar_addr : s0_ar_addr;
                        owner      <= gnt;
                        m_ar_valid <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_ar_ready) begin
                        m_ar_valid <= 1'b0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (m_r_valid && m_r_ready) begin
`ifndef ARB_FIXED_PRIO_EN
                        last  <= owner;
`endif
                        state <= IDLE;
                    end
                end
                default: begin
                    m_ar_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed table, corner sequences and random traffic
// against a transaction-level reference of the read arbiter.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_ar_valid, s0_ar_ready, s0_r_valid, s0_r_ready;
    logic [11:0] s0_ar_addr;
    logic [15:0] s0_r_data;
    logic [1:0]  s0_r_resp;
    logic        s1_ar_valid, s1_ar_ready, s1_r_valid, s1_r_ready;
    logic [11:0] s1_ar_addr;
    logic [15:0] s1_r_data;
    logic [1:0]  s1_r_resp;
    logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [11:0] m_ar_addr;
    logic [15:0] m_r_data;
    logic [1:0]  m_r_resp;

    axi_rd_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready),
        .s0_ar_addr(s0_ar_addr),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
        .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready),
        .s1_ar_addr(s1_ar_addr),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
        .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_addr(m_ar_addr),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    int ncmp = 0;
    int nerr = 0;

    // reference state: pending requests, one transaction in flight
    bit          req [2];
    logic [11:0] raddr [2];
    bit          busy;
    bit          aphase;
    int          own;
    logic [11:0] caddr;
    bit          last_m;
    // slave model
    bit          sl_pend;
    int          sl_dly;
    logic [15:0] sl_data;
    logic [1:0]  sl_resp;
    bit          hold_r;
    bit          fixdata;
    logic [15:0] fx_data;
    logic [1:0]  fx_resp;
    int          ntx;
    bit          last_mrv;
    // knobs
    int p_req = 0;
    int p_arr = 100;
    int p_rr  = 100;
    int dmax  = 0;
    // observations
    int          glog [$];
    logic [11:0] salog [$];
    logic [17:0] rlog0 [$];
    logic [17:0] rlog1 [$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            if (nerr < 40)
                $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int pick();
        if (req[0] && req[1]) return FIXED ? 0 : (last_m ? 0 : 1);
        return req[0] ? 0 : 1;
    endfunction

    task automatic model_reset();
        req[0] = 0; req[1] = 0;
        busy = 0; aphase = 0; own = 0; last_m = 1;
        sl_pend = 0; sl_dly = 0; last_mrv = 0;
    endtask

    task automatic clear_logs();
        glog.delete(); salog.delete(); rlog0.delete(); rlog1.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        s0_ar_valid = 0; s1_ar_valid = 0; s0_ar_addr = 0; s1_ar_addr = 0;
        s0_r_ready = 0; s1_r_ready = 0; m_ar_ready = 0;
        m_r_valid = 0; m_r_data = 0; m_r_resp = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        chk("reset_outputs",
            {s0_ar_ready, s1_ar_ready, m_ar_valid, m_ar_addr, s0_r_valid,
             s0_r_data, s0_r_resp, s1_r_valid, s1_r_data, s1_r_resp, m_r_ready},
            64'h0);
    endtask

    task automatic step();
        bit rr0, rr1, mrv, dat, e0, e1, rro;
        int g;
        logic [53:0] ev, av;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            if (!req[i] && $urandom_range(99) < p_req) begin
                req[i] = 1;
                raddr[i] = 12'($urandom);
            end
        rr0 = $urandom_range(99) < p_rr;
        rr1 = $urandom_range(99) < p_rr;
        mrv = sl_pend && sl_dly == 0 && !hold_r;
        s0_ar_valid = req[0]; s0_ar_addr = raddr[0];
        s1_ar_valid = req[1]; s1_ar_addr = raddr[1];
        s0_r_ready = rr0; s1_r_ready = rr1;
        m_ar_ready = $urandom_range(99) < p_arr;
        m_r_valid = mrv; m_r_data = sl_data; m_r_resp = sl_resp;
        g = -1;
        if (!busy && (req[0] || req[1])) g = pick();
        dat = busy && !aphase;
        e0 = dat && own == 0;
        e1 = dat && own == 1;
        ev = {g == 0, g == 1, busy && aphase,
              (busy && aphase) ? caddr : 12'h0,
              e0 && mrv, e0 ? sl_data : 16'h0, e0 ? sl_resp : 2'b00,
              e1 && mrv, e1 ? sl_data : 16'h0, e1 ? sl_resp : 2'b00,
              (e0 && rr0) || (e1 && rr1)};
        #1;
        av = {s0_ar_ready, s1_ar_ready, m_ar_valid,
              (busy && aphase) ? m_ar_addr : 12'h0,
              s0_r_valid, s0_r_data, s0_r_resp,
              s1_r_valid, s1_r_data, s1_r_resp, m_r_ready};
        chk("cycle", 64'(av), 64'(ev));
        if (s0_ar_valid && s0_ar_ready) glog.push_back(0);
        if (s1_ar_valid && s1_ar_ready) glog.push_back(1);
        if (m_ar_valid && m_ar_ready) salog.push_back(m_ar_addr);
        if (s0_r_valid && s0_r_ready) rlog0.push_back({s0_r_resp, s0_r_data});
        if (s1_r_valid && s1_r_ready) rlog1.push_back({s1_r_resp, s1_r_data});
        last_mrv = mrv;
        rro = (own == 0) ? rr0 : rr1;
        if (sl_pend && sl_dly > 0) sl_dly--;
        if (g >= 0) begin
            req[g] = 0; busy = 1; own = g; aphase = 1; caddr = raddr[g];
        end else if (busy && aphase && m_ar_ready) begin
            aphase = 0; sl_pend = 1;
            sl_dly = $urandom_range(dmax);
            sl_data = fixdata ? fx_data + 16'(ntx) : 16'($urandom);
            sl_resp = fixdata ? fx_resp : 2'($urandom);
            ntx++;
        end else if (dat && mrv && rro) begin
            busy = 0; last_m = (own == 1); sl_pend = 0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((busy || req[0] || req[1]) && k < 500) begin
            step();
            k++;
        end
        chk("drain_timeout", 64'(busy || req[0] || req[1]), 64'h0);
    endtask

    typedef struct {
        bit          v0, v1;
        logic [11:0] a0, a1;
        logic [15:0] d;
        logic [1:0]  resp;
        int          n;
        int          g0, g1;
    } vec_t;

    vec_t vt [5];

    initial begin
        vec_t v;
        logic [11:0] ea;
        logic [17:0] er;
        int cnt;
        rst = 0;
        hold_r = 0; fixdata = 1; fx_data = 0; fx_resp = 0; ntx = 0;
        model_reset();

        vt[0] = '{1, 0, 12'h010, 12'h000, 16'hBEEF, 2'b00, 1, 0, 0};
        vt[1] = '{1, 1, 12'h001, 12'h002, 16'h1234, 2'b00, 2, 0, 1};
        vt[2] = '{0, 1, 12'h000, 12'h0AB, 16'hCAFE, 2'b10, 1, 1, 0};
        vt[3] = '{1, 1, 12'h3FF, 12'hFFF, 16'h0000, 2'b01, 2, 0, 1};
        vt[4] = '{0, 1, 12'h000, 12'hFFF, 16'hFFFF, 2'b11, 1, 1, 0};

        // table-driven single and paired reads from reset
        for (int t = 0; t < 5; t++) begin
            v = vt[t];
            do_reset();
            clear_logs();
            ntx = 0; fx_data = v.d; fx_resp = v.resp;
            dmax = 2; p_arr = 70; p_rr = 70;
            if (v.v0) begin req[0] = 1; raddr[0] = v.a0; end
            if (v.v1) begin req[1] = 1; raddr[1] = v.a1; end
            drain();
            chk("tbl_ngrant", 64'(glog.size()), 64'(v.n));
            chk("tbl_beats", 64'(rlog0.size() + rlog1.size()), 64'(v.n));
            for (int j = 0; j < v.n && j < glog.size(); j++) begin
                int gm;
                gm = (j == 0) ? v.g0 : v.g1;
                chk("tbl_grant", 64'(glog[j]), 64'(gm));
                ea = (gm == 0) ? v.a0 : v.a1;
                if (j < salog.size()) chk("tbl_slave_addr", 64'(salog[j]), 64'(ea));
                er = {v.resp, v.d + 16'(j)};
                if (gm == 0 && rlog0.size() > 0) chk("tbl_r0", 64'(rlog0[0]), 64'(er));
                if (gm == 1 && rlog1.size() > 0) chk("tbl_r1", 64'(rlog1[0]), 64'(er));
            end
        end

        // arrival order swapped, then a tie after master 0 was served last
        do_reset();
        clear_logs();
        dmax = 0; p_arr = 100; p_rr = 100;
        req[1] = 1; raddr[1] = 12'h002;
        step();
        req[0] = 1; raddr[0] = 12'h001;
        drain();
        req[0] = 1; raddr[0] = 12'h005;
        req[1] = 1; raddr[1] = 12'h006;
        drain();
        chk("swap_n", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) begin
            chk("swap_g0", 64'(glog[0]), 64'd1);
            chk("swap_g1", 64'(glog[1]), 64'd0);
            chk("swap_g2", 64'(glog[2]), FIXED ? 64'd0 : 64'd1);
            chk("swap_g3", 64'(glog[3]), FIXED ? 64'd1 : 64'd0);
        end

        // continuous contention for 8 transactions
        do_reset();
        clear_logs();
        p_req = 100;
        cnt = 0;
        while (glog.size() < 8 && cnt < 200) begin
            step();
            cnt++;
        end
        p_req = 0;
        drain();
        chk("cont_n_ge8", 64'(glog.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < glog.size(); k++)
            chk("cont_order", 64'(glog[k]), FIXED ? 64'd0 : 64'(k % 2));

        // backpressure on AR then on R
        do_reset();
        clear_logs();
        p_arr = 0;
        req[0] = 1; raddr[0] = 12'h123;
        for (int k = 0; k < 6; k++) step();
        p_arr = 100; p_rr = 0; dmax = 0;
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 3; k++) begin
            step();
            if (last_mrv) cnt++;
        end
        chk("bp_rstall", 64'(cnt), 64'd3);
        chk("bp_no_beat", 64'(rlog0.size()), 64'd0);
        p_rr = 100;
        drain();
        chk("bp_beats", 64'(rlog0.size()), 64'd1);
        chk("bp_addr_n", 64'(salog.size()), 64'd1);
        if (salog.size() == 1) chk("bp_addr", 64'(salog[0]), 64'h123);

        // reset while waiting for R, then a fresh master 1 read
        do_reset();
        clear_logs();
        hold_r = 1;
        req[1] = 1; raddr[1] = 12'h055;
        cnt = 0;
        while (!(busy && !aphase) && cnt < 50) begin
            step();
            cnt++;
        end
        step(); step();
        chk("rst_in_data", 64'(busy && !aphase), 64'd1);
        do_reset();
        hold_r = 0;
        clear_logs();
        req[1] = 1; raddr[1] = 12'h066;
        drain();
        chk("rst_regrant_n", 64'(glog.size()), 64'd1);
        if (glog.size() == 1) chk("rst_regrant", 64'(glog[0]), 64'd1);
        if (salog.size() == 1) chk("rst_addr", 64'(salog[0]), 64'h066);
        chk("rst_beat", 64'(rlog1.size()), 64'd1);

        // random traffic against the reference
        do_reset();
        fixdata = 0;
        p_req = 40; p_arr = 60; p_rr = 60; dmax = 3;
        for (int k = 0; k < 3000; k++) step();
        p_req = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
